// File: rtl/cadc_rom_pkg.sv
// Shared constants and types for the CADC microcode/constant ROM and its arbiter.
package cadc_rom_pkg;
  localparam int ROM_DEPTH = 128;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 20;

  typedef logic [DATA_W-1:0] rom_word_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: combinational grant from req and ptr, registered ptr.
module rr_arbiter
  import cadc_rom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);
  logic [PTR_W-1:0] ptr_q;
  logic             found;
  int               j;

  // Search ptr, ptr+1, ... wrapping; first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && rst_n && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      ptr_q <= '0;
    else if (found)  ptr_q <= PTR_W'(wrap_inc(int'(idx_o), NUM_REQ));
  end
endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM among NUM_REQ requesters; 3-cycle read pipeline with id tracking.
module rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = cadc_rom_pkg::ADDR_W,
  parameter int DATA_W  = cadc_rom_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   gidx;
  logic               xfer;
  logic [1:0]         vld_q;
  logic [PTR_W-1:0]   id1_q, id2_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign xfer = |gnt;

  // vld_q[0]: ROM access this cycle; vld_q[1]: ROM data on rom_data this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      id1_q      <= '0;
      id2_q      <= '0;
      rom_addr_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      vld_q[0] <= xfer;
      vld_q[1] <= vld_q[0];
      if (xfer) begin
        rom_addr_q <= addr[int'(gidx)*ADDR_W +: ADDR_W];
        id1_q      <= gidx;
      end
      id2_q    <= id1_q;
      rvalid_q <= '0;
      if (vld_q[1]) begin
        rvalid_q[id2_q] <= 1'b1;
        rdata_q         <= rom_data;
      end
    end
  end

  assign rom_en   = vld_q[0];
  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter and read sequencer sharing one 128 x 20-bit synchronous ROM among NUM_REQ requesters, such as the CADC computation modules. Accepts one read per cycle via a req/gnt handshake and drives the ROM address and enable. Routes each returned word back to its requester with a fixed 3-cycle latency. Sits between the processing-module sequencers and the microcode/constant ROM.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 7, ROM address width (128 words)
- DATA_W, 20, ROM word width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester read request
- addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = addr[i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rom_en  out  1  registered ROM read enable
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_en
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata belongs to requester i
- rdata  out  DATA_W  registered read data, shared by all requesters

## Operation
- Transfer occurs in a cycle where req[i] && gnt[i]. Requester holds req[i] and addr slice stable until granted. It may keep req high for back-to-back reads.
- gnt is zero while rst_n is low, and zero when req is zero. Otherwise exactly one bit is set.
- Round-robin: ptr (clog2(NUM_REQ) bits) names the highest-priority requester. Search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- On a transfer to i, ptr <= (i+1) mod NUM_REQ. No transfer: ptr holds.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 cycles for a grant.
- Pipeline stage 1 (t+1): rom_en=1, rom_addr=granted addr, id1=i. Stage 2 (t+2): ROM presents rom_data, id2=id1. Stage 3 (t+3): rdata<=rom_data, rvalid[id2]=1.
- A valid bit accompanies each stage. rom_en=0 when no transfer occurred; rom_addr then holds its last value.
- No backpressure on the read-data path. Requesters must consume rdata in the rvalid cycle.
- rdata holds its last value when rvalid is all-zero.
- Addresses wrap naturally within ADDR_W bits; no range check.

## Timing
- Reset values: ptr=0, rom_en=0, rom_addr=0, all stage valids=0, rvalid=0, rdata=0.
- Read latency: transfer at cycle t gives rvalid/rdata at t+3.
- Throughput: one read per cycle sustained, any mix of requesters.
- Reset asserted mid-operation: in-flight reads are discarded, no rvalid is produced for them, and ptr returns to 0 on the next edge.
- First cycle after rst_n deasserts: arbitration is live and gnt may assert combinationally.
- Simultaneous requests: exactly one grant per cycle. Non-granted requesters keep their request pending; nothing is queued internally.
- Single requester with req held high: granted every cycle.

## Structure
- Shared package cadc_rom_pkg: ROM_DEPTH=128, ADDR_W=7, DATA_W=20 constants, and a rom_word_t typedef (DATA_W bits).
- Sub-module rr_arbiter: purely combinational one-hot select from req and ptr, plus the registered ptr update. It is reusable elsewhere.
- rom_arbiter instantiates rr_arbiter and contains the address mux, the 3-stage id/valid pipeline and the rdata register. ROM instantiation is external.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, rom_en=0, rvalid=0, rdata=0.
- Single read: req[2]=1, addr2=7'h15, ROM word 0x15=20'hABCDE → gnt=4'b0100 at t, rom_addr=7'h15 at t+1, rvalid=4'b0100 and rdata=20'hABCDE at t+3.
- Contention: all four req high from reset for 8 cycles → grants 0,1,2,3,0,1,2,3. rvalid follows the same order three cycles later, each word matching its requester's address.
- Back-to-back single requester: req[1] held with addr stepping 0..5 → six consecutive grants, six consecutive rvalid[1] pulses with ROM words 0..5 in order.
- Pointer wrap: req[3] granted, then req=4'b1001 → next grant is 0, then 3.
- Mid-flight reset: grant at t, rst_n=0 at t+2 for one cycle → no rvalid at t+3, and ptr=0 afterwards.
